// File: rtl/vga_scan_timing_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_timing_if : raster coordinates, strobes and sync outputs    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface vga_scan_if;
  logic [10:0] visible_col;
  logic [10:0] visible_row;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_tick;

  modport master (
    output visible_col, visible_row, pix_en, hsync, vsync, video_on, frame_tick
  );

  modport slave (
    input  visible_col, visible_row, pix_en, hsync, vsync, video_on, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/vga_scan_timing.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_scan_timing : pixel divider, raster counters, delayed sync decode|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module vga_scan_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       BTN_S,
  vga_scan_if.master vga
);

  localparam int          c_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int          c_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  c_DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);
  localparam logic [10:0] c_H_VIS    = 11'(H_VIS);
  localparam logic [10:0] c_V_VIS    = 11'(V_VIS);
  localparam logic [10:0] c_HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] c_VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  logic [3:0]  r_div_cnt;
  logic [10:0] r_col;
  logic [10:0] r_row;
  logic        r_frame_tick;
  logic        w_pix_en;
  logic        w_h_end;
  logic        w_v_end;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_vo_raw;

  assign w_pix_en = (r_div_cnt == c_DIV_LAST);
  assign w_h_end  = (r_col == c_H_LAST);
  assign w_v_end  = (r_row == c_V_LAST);

  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      r_div_cnt <= 4'd0;
    end else if (w_pix_en) begin
      r_div_cnt <= 4'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge BTN_S) begin
    if (BTN_S) begin
      r_col        <= 11'd0;
      r_row        <= 11'd0;
      r_frame_tick <= 1'b0;
    end else begin
      // Tick is registered on the wrap edge so it lines up with the (0,0) count.
      r_frame_tick <= w_pix_en & w_h_end & w_v_end;
      if (w_pix_en) begin
        if (w_h_end) begin
          r_col <= 11'd0;
          r_row <= w_v_end ? 11'd0 : r_row + 11'd1;
        end else begin
          r_col <= r_col + 11'd1;
        end
      end
    end
  end

  assign w_hs_raw = ~((r_col >= c_HS_START) && (r_col < c_HS_END));
  assign w_vs_raw = ~((r_row >= c_VS_START) && (r_row < c_VS_END));
  assign w_vo_raw = (r_col < c_H_VIS) && (r_row < c_V_VIS);

  // Stages advance every clk so the lag is in clocks, matching downstream registers.
  generate
    if (PIPE_DLY == 0) begin : g_dly_none
      assign vga.hsync    = w_hs_raw;
      assign vga.vsync    = w_vs_raw;
      assign vga.video_on = w_vo_raw;
    end else begin : g_dly_pipe
      logic [2:0] r_stage [PIPE_DLY];

      always_ff @(posedge clk or posedge BTN_S) begin
        if (BTN_S) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            r_stage[i] <= 3'b110;
          end
        end else begin
          r_stage[0] <= {w_hs_raw, w_vs_raw, w_vo_raw};
          for (int i = 1; i < PIPE_DLY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign {vga.hsync, vga.vsync, vga.video_on} = r_stage[PIPE_DLY-1];
    end
  endgenerate

  assign vga.visible_col = r_col;
  assign vga.visible_row = r_row;
  assign vga.pix_en      = w_pix_en;
  assign vga.frame_tick  = r_frame_tick;

endmodule
`default_nettype wire
